sm4_key_expand: RTL and testbench
=================================

Name: sm4_key_expand

Overview:
Sequential SM4 key-expansion engine; sits directly upstream of the round/cipher datapath.
Accepts a 128-bit master key MK, whitens it with FK, and iterates the combinational round-key stage (rk_calculate) once per clock for 32 rounds.
Streams rk0..rk31 in order with valid/index, and optionally holds all 32 keys for random-access reads by the decrypt path.

Parameters:
NUM_ROUNDS, 32, number of round keys produced; fixed by SM4, not to be overridden.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; accepted only when busy=0
mk  input  128  master key, MK0=mk[127:96] .. MK3=mk[31:0]; sampled on accepted start
busy  output  1  high from the accepting edge until the edge that produces rk31
rk_valid  output  1  rk_out/rk_idx valid this cycle
rk_out  output  32  current round key
rk_idx  output  5  index i of rk_out
done  output  1  one-cycle pulse, coincident with rk_idx=31
keys_valid  output  1  stored set complete and consistent with the last mk
rd_addr  input  5  store read address
rd_data  output  32  registered store read data

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, rk_valid, done, keys_valid = 0; rk_out, rk_idx, rd_data = 0; K-regs = 0; round counter = 0.
- FSM IDLE -> RUN -> IDLE.
- IDLE: start=1 at edge T loads K0..K3 = MK ^ FK, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC. Sets round=0, busy=1, keys_valid=0.
- RUN, each edge T+1+i for i = 0..31:
  - rk_out = K0 ^ T'(K1^K2^K3^CK[i]), computed by rk_calculate with round={27'b0,i}.
  - rk_idx=i, rk_valid=1.
  - K-regs shift: K0<=K1, K1<=K2, K2<=K3, K3<=rk_out.
  - round increments.
- Edge T+32 (i=31): done=1, keys_valid=1, busy=0, state -> IDLE.
- Latency: rk0 is visible 1 cycle after the start edge; the full set takes 32 cycles. Back-to-back: a start in the cycle after done is accepted.
- rk_valid and done are registered pulses and drop the following cycle unless RUN continues.
- start while busy=1 is ignored; mk is not re-sampled and the sequence is unaffected.
- Round counter is 5-bit and never wraps inside RUN; the exit is decoded at round=31.
- Reset mid-RUN aborts immediately: all outputs return to reset values and keys_valid=0. Store contents are undefined after an abort.
- mk may change freely after the accepting edge.

Optional Feature:
SM4_KEY_STORE_EN
- Defined:
  - 32x32 register store written at each RUN edge at address rk_idx.
  - rd_data <= store[rd_addr] every edge (1-cycle read latency).
  - A read of the address being written on the same edge returns the old value.
  - Store is not cleared by reset; keys_valid qualifies it.
- Undefined: no store; rd_data held at 0; rd_addr unused; keys_valid still tracks completion.

Decomposition:
- Package sm4_pkg holds:
  - FK0..FK3 constants
  - state enum (IDLE, RUN)
  - round-index width constant (5)
  - key-word width (32)
- Single sub-module: the existing combinational rk_calculate, instantiated once; the FSM, K-regs and store stay in sm4_key_expand.
- S-box and CK tables are not duplicated here.

Test Plan:
1. Reset, then start with mk=0123456789ABCDEFFEDCBA9876543210 -> rk0=F12186F9 at T+1, rk1=41662B61 at T+2, rk31=9124A012 at T+32 with done=1 and keys_valid=1; exactly 32 rk_valid cycles.
2. start re-pulsed with a different mk at T+5 and T+20 -> ignored; output sequence identical to scenario 1.
3. Reset asserted asynchronously at T+10 (mid-clock) -> busy, rk_valid, keys_valid = 0 immediately. A new start after release reproduces scenario 1 from rk0.
4. Back-to-back: second start (mk=0) in the cycle after done -> accepted, busy rises again, keys_valid=0 until the second done; rk0 matches the golden model for MK=0.
5. SM4_KEY_STORE_EN defined: after scenario 1, sweep rd_addr 31 down to 0 -> rd_data equals rk31..rk0 one cycle later (9124A012 first).
6. SM4_KEY_STORE_EN undefined: same sweep -> rd_data stays 0; streaming outputs unchanged from scenario 1.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule definitions: FK whitening words, widths and FSM states.
package sm4_pkg;

    localparam int KW         = 32;
    localparam int RW         = 5;
    localparam int NUM_ROUNDS = 32;

    localparam logic [KW-1:0] FK0 = 32'hA3B1BAC6;
    localparam logic [KW-1:0] FK1 = 32'h56AA3350;
    localparam logic [KW-1:0] FK2 = 32'h677D9197;
    localparam logic [KW-1:0] FK3 = 32'hB27022DC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sm4_key_expand_rk_calculate.sv
// SM4 key-schedule round stage: rk = K0 ^ T'(K1 ^ K2 ^ K3 ^ CK[round]).
// Purely combinational; CK bytes are generated as (4i+j)*7 mod 256 instead of tabulated.
module rk_calculate
    import sm4_pkg::*;
(
    input  logic [KW-1:0] k0,
    input  logic [KW-1:0] k1,
    input  logic [KW-1:0] k2,
    input  logic [KW-1:0] k3,
    input  logic [31:0]   round,
    output logic [KW-1:0] rk
);

    // Byte 0 of the S-box sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[2047 - 8*int'(a) -: 8];
    endfunction

    logic [KW-1:0] ck;
    logic [KW-1:0] a;
    logic [KW-1:0] b;

    always_comb begin
        ck = '0;
        for (int j = 0; j < 4; j++) begin
            ck[31-8*j -: 8] = 8'((round * 32'd4 + 32'(j)) * 32'd7);
        end
    end

    assign a = k1 ^ k2 ^ k3 ^ ck;
    assign b = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    assign rk = k0 ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

endmodule

// File: rtl/sm4_key_expand.sv
// Sequential SM4 key expansion: one round key per clock, rk0..rk31 streamed with index.
// Define SM4_KEY_STORE_EN to keep all 32 keys in a register store for random-access reads.
module sm4_key_expand
    import sm4_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [127:0]  mk,
    output logic          busy,
    output logic          rk_valid,
    output logic [KW-1:0] rk_out,
    output logic [RW-1:0] rk_idx,
    output logic          done,
    output logic          keys_valid,
    input  logic [RW-1:0] rd_addr,
    output logic [KW-1:0] rd_data
);

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] round;
    logic [KW-1:0] k0, k1, k2, k3;
    logic [KW-1:0] rk_next;
    logic          load;
    logic          step;
    logic          last;

    assign last = (round == RW'(NUM_ROUNDS - 1));
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    rk_calculate u_rk_calculate (
        .k0    (k0),
        .k1    (k1),
        .k2    (k2),
        .k3    (k3),
        .round ({{(32-RW){1'b0}}, round}),
        .rk    (rk_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k0         <= '0;
            k1         <= '0;
            k2         <= '0;
            k3         <= '0;
            round      <= '0;
            rk_out     <= '0;
            rk_idx     <= '0;
            rk_valid   <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            rk_valid <= step;
            done     <= step && last;
            if (load) begin
                k0         <= mk[127:96] ^ FK0;
                k1         <= mk[95:64]  ^ FK1;
                k2         <= mk[63:32]  ^ FK2;
                k3         <= mk[31:0]   ^ FK3;
                round      <= '0;
                keys_valid <= 1'b0;
            end else if (step) begin
                k0     <= k1;
                k1     <= k2;
                k2     <= k3;
                k3     <= rk_next;
                rk_out <= rk_next;
                rk_idx <= round;
                round  <= last ? '0 : round + RW'(1);
                if (last) keys_valid <= 1'b1;
            end
        end
    end

`ifdef SM4_KEY_STORE_EN
    // Not reset: keys_valid is what tells the reader the contents are usable.
    logic [KW-1:0] store [NUM_ROUNDS];

    always_ff @(posedge clk) begin
        if (step) store[round] <= rk_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= store[rd_addr];
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand: vector table, scoreboard monitor and corner sequences.
module tb_sm4_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] mk;
    logic         busy, rk_valid, done, keys_valid;
    logic [31:0]  rk_out, rd_data;
    logic [4:0]   rk_idx, rd_addr;

    int n_cmp  = 0;
    int n_err  = 0;
    int nvalid = 0;

    logic [36:0] sb_q [$];
    logic [31:0] cap [32];

    localparam logic [127:0] STD_MK = 128'h0123456789ABCDEFFEDCBA9876543210;

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef struct {
        logic [127:0] key;
        logic         kat;
        logic [31:0]  rk0;
        logic [31:0]  rk1;
        logic [31:0]  rk31;
    } vec_t;

    always #5 clk = ~clk;

    sm4_key_expand dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mk         (mk),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_out     (rk_out),
        .rk_idx     (rk_idx),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    function automatic logic [7:0] sb(input logic [7:0] a);
        return SBOX[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [31:0] ck_word(input int i);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) w = {w[23:0], 8'((4*i + j) * 7)};
        return w;
    endfunction

    // Reference key schedule: returns rk_n for master key mk.
    function automatic logic [31:0] model_rk(input logic [127:0] key, input int n);
        logic [31:0] k [4];
        logic [31:0] t;
        logic [31:0] r = '0;
        k[0] = key[127:96] ^ 32'hA3B1BAC6;
        k[1] = key[95:64]  ^ 32'h56AA3350;
        k[2] = key[63:32]  ^ 32'h677D9197;
        k[3] = key[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i <= n; i++) begin
            t = k[1] ^ k[2] ^ k[3] ^ ck_word(i);
            t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
            r = k[0] ^ t ^ {t[18:0], t[31:19]} ^ {t[8:0], t[31:9]};
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = r;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rk_valid) begin
                    nvalid++;
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_rk: got idx %0d rk %h, required no output", rk_idx, rk_out);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rk_idx", 32'(rk_idx), 32'(e[36:32]));
                        chk("rk_out", rk_out, e[31:0]);
                        chk("done_at_idx", 32'(done), 32'(rk_idx == 5'd31));
                        chk("keys_valid_at_idx", 32'(keys_valid), 32'(rk_idx == 5'd31));
                        chk("busy_in_run", 32'(busy), 32'(rk_idx != 5'd31));
                        cap[rk_idx] = rk_out;
                    end
                end else begin
                    chk("done_idle", 32'(done), 32'd0);
                end
            end
        end
    endtask

    // Called just after a negedge; start is sampled at the next rising edge.
    task automatic run_one(input logic [127:0] k, input int p1, input int p2);
        int   base;
        int   c;
        logic seen;
        base = nvalid;
        for (int i = 0; i < 32; i++) cap[i] = '0;
        start = 1'b1;
        mk    = k;
        for (int i = 0; i < 32; i++) sb_q.push_back({5'(i), model_rk(k, i)});
        @(posedge clk);
        #1;
        start = 1'b0;
        mk    = {$urandom, $urandom, $urandom, $urandom};
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("kv_cleared_on_start", 32'(keys_valid), 32'd0);
        seen = 1'b0;
        c    = 0;
        while (!seen && c < 40) begin
            @(negedge clk);
            #1;
            c++;
            start = (c == p1 || c == p2);
            if (start) mk = ~k;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_latency", 32'(c), 32'd33);
        chk("kv_at_done", 32'(keys_valid), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("rk_valid_count", 32'(nvalid - base), 32'd32);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic kat_std();
        chk("kat_rk0", cap[0], 32'hF12186F9);
        chk("kat_rk1", cap[1], 32'h41662B61);
        chk("kat_rk31", cap[31], 32'h9124A012);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        vecs[0] = '{STD_MK, 1'b1, 32'hF12186F9, 32'h41662B61, 32'h9124A012};
        vecs[1] = '{128'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[2] = '{{4{32'hFFFFFFFF}}, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{128'hDEADBEEF0BADF00DCAFEBABE12345678, 1'b0, 32'h0, 32'h0, 32'h0};

        rst = 1'b1; start = 1'b0; mk = '0; rd_addr = '0;
        fork
            monitor();
        join_none

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rk_valid", 32'(rk_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_keys_valid", 32'(keys_valid), 32'd0);
        chk("rst_rk_out", rk_out, 32'd0);
        chk("rst_rk_idx", 32'(rk_idx), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            run_one(vecs[v].key, 0, 0);
            if (vecs[v].kat) begin
                chk("vec_rk0", cap[0], vecs[v].rk0);
                chk("vec_rk1", cap[1], vecs[v].rk1);
                chk("vec_rk31", cap[31], vecs[v].rk31);
            end
        end

        // Re-pulsed start with a different key while busy must be ignored.
        @(negedge clk);
        run_one(STD_MK, 5, 20);
        kat_std();

        for (int a = 31; a >= 0; a--) begin
            @(negedge clk);
            rd_addr = 5'(a);
            @(negedge clk);
`ifdef SM4_KEY_STORE_EN
            chk("rd_data", rd_data, model_rk(STD_MK, a));
`else
            chk("rd_data", rd_data, 32'd0);
`endif
        end

        // Asynchronous abort in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        mk    = STD_MK;
        for (int i = 0; i < 32; i++) sb_q.push_back({5'(i), model_rk(STD_MK, i)});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        #1;
        chk("rk_valid_before_abort", 32'(rk_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rk_valid", 32'(rk_valid), 32'd0);
        chk("abort_keys_valid", 32'(keys_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rk_out", rk_out, 32'd0);
        chk("abort_rk_idx", 32'(rk_idx), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_one(STD_MK, 0, 0);
        kat_std();

        // Back-to-back: next start issued during the done cycle.
        @(negedge clk);
        run_one(STD_MK, 0, 0);
        run_one(128'h0, 0, 0);
        chk("b2b_rk0", cap[0], model_rk(128'h0, 0));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
